// File: rtl/axi_sample_dma_pkg.sv
// Shared constants and FSM encoding for the sample DMA master.
package axi_sample_dma_pkg;

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned SAMPLE_W = 16;

    localparam logic [3:0] STRB_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/axi_sample_dma_if.sv
// Single-beat request/response bus between a master and the system arbiter.
interface axi_sample_dma_if;
    import axi_sample_dma_pkg::*;

    logic              avalid;
    logic              aready;
    logic              awe;
    logic [ADDR_W-1:0] aaddr;
    logic [DATA_W-1:0] adata;
    logic [3:0]        astrb;
    logic              bvalid;
    logic [DATA_W-1:0] bdata;

    modport master (
        output avalid, awe, aaddr, adata, astrb,
        input  aready, bvalid, bdata
    );

    modport slave (
        input  avalid, awe, aaddr, adata, astrb,
        output aready, bvalid, bdata
    );

endinterface

// File: rtl/axi_sample_dma_sync_word_fifo.sv
// Single-clock word FIFO with first-word-fall-through head.
module sync_word_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];
    // A pop on a full FIFO frees the slot in the same cycle, so the push still lands.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/axi_sample_dma.sv
// Packs 16-bit samples into words and writes them into a memory ring buffer.
module axi_sample_dma
    import axi_sample_dma_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned LEN_W   = 14
) (
    input  logic                rst_n,
    input  logic                clk,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_strobe,
    input  logic                cfg_enable,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [LEN_W-1:0]    cfg_len,
    axi_sample_dma_if.master    bus,
    output logic [LEN_W-1:0]    wr_index,
    output logic                overflow,
    output logic                busy
);
    logic                active;
    logic                half_pending;
    logic [SAMPLE_W-1:0] half_lo;
    logic [ADDR_W-1:0]   base_l;
    logic [LEN_W-1:0]    len_l;
    state_t              state;
    logic                avalid_q;
    logic [ADDR_W-1:0]   aaddr_q;
    logic [DATA_W-1:0]   adata_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_head;

    logic                start_c;
    logic                push_c;
    logic                pop_c;
    logic                push_ok_c;
    logic                active_d_c;
    logic                busy_d_c;
    logic [LEN_W-1:0]    idx_inc_c;
    logic                unused_bdata;

    assign bus.avalid   = avalid_q;
    assign bus.aaddr    = aaddr_q;
    assign bus.adata    = adata_q;
    assign bus.awe      = 1'b1;
    assign bus.astrb    = STRB_ALL;
    assign unused_bdata = ^bus.bdata;

    assign start_c    = cfg_enable && !active && !busy && (cfg_len != '0);
    assign push_c     = active && cfg_enable && in_strobe && half_pending;
    assign pop_c      = !fifo_empty && ((state == ST_IDLE) || ((state == ST_RESP) && bus.bvalid));
    assign push_ok_c  = push_c && (!fifo_full || pop_c);
    assign active_d_c = start_c || (active && cfg_enable);
    // Busy reflects next-cycle state so it falls in the same cycle the FSM returns to IDLE.
    assign busy_d_c   = active_d_c || !fifo_empty || push_ok_c || (state == ST_REQ) ||
                        ((state == ST_RESP) && !bus.bvalid);
    assign idx_inc_c  = (wr_index == len_l - LEN_W'(1)) ? '0 : wr_index + LEN_W'(1);

    sync_word_fifo #(
        .AW (FIFO_AW),
        .DW (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata ({in_data, half_lo}),
        .pop   (pop_c),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Session control, sample packer and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= 1'b0;
            half_pending <= 1'b0;
            half_lo      <= '0;
            base_l       <= '0;
            len_l        <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy <= busy_d_c;
            if (start_c) begin
                active       <= 1'b1;
                half_pending <= 1'b0;
                base_l       <= cfg_base;
                len_l        <= cfg_len;
                overflow     <= 1'b0;
            end else begin
                if (!cfg_enable) begin
                    active       <= 1'b0;
                    half_pending <= 1'b0;
                end else if (active && in_strobe) begin
                    if (!half_pending) half_lo <= in_data;
                    half_pending <= !half_pending;
                end
                if (push_c && fifo_full && !pop_c) overflow <= 1'b1;
            end
        end
    end

    // Bus master FSM: one outstanding single-beat write at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            avalid_q <= 1'b0;
            aaddr_q  <= '0;
            adata_q  <= '0;
            wr_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        avalid_q <= 1'b1;
                        adata_q  <= fifo_head;
                        aaddr_q  <= base_l + ADDR_W'(wr_index);
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.aready) begin
                        avalid_q <= 1'b0;
                        wr_index <= idx_inc_c;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.bvalid) begin
                        if (pop_c) begin
                            avalid_q <= 1'b1;
                            adata_q  <= fifo_head;
                            aaddr_q  <= base_l + ADDR_W'(wr_index);
                            state    <= ST_REQ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (start_c) wr_index <= '0;
        end
    end

endmodule
